// File: rtl/rv32i_fetch_decode_alu.sv
// RV32I fetch pass-through, field/immediate decode and OP/OP-IMM ALU; purely combinational.
// Define RV_DECODE_STRICT_EN to also validate funct3/funct7 per opcode.
module rv32i_fetch_decode_alu #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic [31:0]           i_pc,
  output logic [ADDR_WIDTH:0]   o_read_fetch_addr,
  input  logic [DATA_WIDTH:0]   i_read_fetch_data,
  output logic [31:0]           o_instruction,
  output logic [6:0]            o_opcode,
  output logic [4:0]            o_rd,
  output logic [2:0]            o_funct3,
  output logic [4:0]            o_rs1,
  output logic [4:0]            o_rs2,
  output logic [7:0]            o_funct7,
  output logic [31:0]           o_imm,
  output logic                  o_valid,
  input  logic [DATA_WIDTH:0]   i_rs1_data,
  input  logic [DATA_WIDTH:0]   i_rs2_data,
  output logic [DATA_WIDTH:0]   o_rd_data
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [31:0]        instr;
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7_raw;
  logic               opcode_ok;
  logic               strict_ok;
  logic signed [31:0] rs1_s;
  logic signed [31:0] rs2_s;
  logic signed [31:0] imm_s;
  logic               unused_ok;

  // Clock and enable only matter to downstream samplers; nothing here is clocked.
  assign unused_ok = ^{clk, clk_en};

  generate
    if (ADDR_WIDTH + 1 == 32) begin : g_addr_eq
      assign o_read_fetch_addr = i_pc;
    end else if (ADDR_WIDTH + 1 > 32) begin : g_addr_ext
      assign o_read_fetch_addr = {{(ADDR_WIDTH + 1 - 32){1'b0}}, i_pc};
    end else begin : g_addr_trunc
      assign o_read_fetch_addr = i_pc[ADDR_WIDTH:0];
    end
  endgenerate

  // Forcing the word to zero under reset zeroes every derived output too.
  assign instr         = rst ? 32'd0 : i_read_fetch_data;
  assign o_instruction = instr;
  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7_raw    = instr[31:25];
  assign o_opcode      = opcode;
  assign o_rd          = instr[11:7];
  assign o_funct3      = funct3;
  assign o_rs1         = instr[19:15];
  assign o_rs2         = instr[24:20];
  assign o_funct7      = {1'b0, funct7_raw};

  always_comb begin
    o_imm = 32'd0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
        o_imm = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:
        o_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:
        o_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_JAL:
        o_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      OP_LUI, OP_AUIPC:
        o_imm = {12'd0, instr[31:12]};
      default: o_imm = 32'd0;
    endcase
  end

  always_comb begin
    opcode_ok = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: opcode_ok = 1'b1;
      default: opcode_ok = 1'b0;
    endcase
  end

`ifdef RV_DECODE_STRICT_EN
  always_comb begin
    strict_ok = 1'b1;
    case (opcode)
      OP_REG:
        strict_ok = (funct7_raw == 7'b0000000) ||
                    (funct7_raw == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
      OP_IMM:
        if (funct3 == 3'b001)      strict_ok = (funct7_raw == 7'b0000000);
        else if (funct3 == 3'b101) strict_ok = (funct7_raw == 7'b0000000) || (funct7_raw == 7'b0100000);
      OP_LOAD:   strict_ok = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      OP_STORE:  strict_ok = (funct3 inside {3'b000, 3'b001, 3'b010});
      OP_BRANCH: strict_ok = !(funct3 inside {3'b010, 3'b011});
      OP_JALR:   strict_ok = (funct3 == 3'b000);
      default:   strict_ok = 1'b1;
    endcase
  end
`else
  assign strict_ok = 1'b1;
`endif

  assign o_valid = !rst && (instr != 32'd0) && opcode_ok && strict_ok;

  // alt selects SUB (funct3 000) or arithmetic right shift (funct3 101).
  function automatic logic [31:0] alu_op(input logic [2:0] f3, input logic alt,
                                         input logic signed [31:0] a,
                                         input logic signed [31:0] b,
                                         input logic [4:0] shamt);
    logic [31:0] r;
    r = 32'd0;
    case (f3)
      3'b000: r = alt ? (a - b) : (a + b);
      3'b001: r = a << shamt;
      3'b010: r = {31'd0, (a < b)};
      3'b011: r = {31'd0, ($unsigned(a) < $unsigned(b))};
      3'b100: r = a ^ b;
      3'b101: begin
        if (alt) r = a >>> shamt;
        else     r = $unsigned(a) >> shamt;
      end
      3'b110: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  assign rs1_s = i_rs1_data;
  assign rs2_s = i_rs2_data;
  assign imm_s = o_imm;

  always_comb begin
    o_rd_data = '0;
    case (opcode)
      OP_REG: o_rd_data = alu_op(funct3, instr[30], rs1_s, rs2_s, rs2_s[4:0]);
      OP_IMM: o_rd_data = alu_op(funct3, instr[30] && (funct3 == 3'b101), rs1_s, imm_s, imm_s[4:0]);
      default: o_rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_rv32i_fetch_decode_alu.sv
// Scoreboard bench for rv32i_fetch_decode_alu: directed vectors with hand-computed results.
module tb_rv32i_fetch_decode_alu;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic [31:0] i_pc;
  logic [31:0] o_read_fetch_addr;
  logic [31:0] i_read_fetch_data;
  logic [31:0] o_instruction;
  logic [6:0]  o_opcode;
  logic [4:0]  o_rd;
  logic [2:0]  o_funct3;
  logic [4:0]  o_rs1;
  logic [4:0]  o_rs2;
  logic [7:0]  o_funct7;
  logic [31:0] o_imm;
  logic        o_valid;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic [31:0] o_rd_data;

  rv32i_fetch_decode_alu #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .i_pc(i_pc),
    .o_read_fetch_addr(o_read_fetch_addr), .i_read_fetch_data(i_read_fetch_data),
    .o_instruction(o_instruction), .o_opcode(o_opcode), .o_rd(o_rd),
    .o_funct3(o_funct3), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_funct7(o_funct7),
    .o_imm(o_imm), .o_valid(o_valid), .i_rs1_data(i_rs1_data),
    .i_rs2_data(i_rs2_data), .o_rd_data(o_rd_data)
  );

`ifdef RV_DECODE_STRICT_EN
  localparam logic STRICT = 1'b1;
`else
  localparam logic STRICT = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        valid;
    logic [31:0] rd_data;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic stim_vld = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got 0x%08h expected 0x%08h", name, field, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (stim_vld) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard: got output with empty queue expected an entry");
      end else begin
        e = sb.pop_front();
        check(e.name, "instr",   o_instruction,          e.instr);
        check(e.name, "opcode",  {25'd0, o_opcode},      {25'd0, e.op});
        check(e.name, "rd",      {27'd0, o_rd},          {27'd0, e.rd});
        check(e.name, "imm",     o_imm,                  e.imm);
        check(e.name, "valid",   {31'd0, o_valid},       {31'd0, e.valid});
        check(e.name, "rd_data", o_rd_data,              e.rd_data);
        check(e.name, "addr",    o_read_fetch_addr,      e.addr);
      end
    end
  end

  task automatic send(input string name, input logic r, input logic [31:0] pc,
                      input logic [31:0] data, input logic [31:0] a, input logic [31:0] b,
                      input logic [6:0] op, input logic [4:0] rd, input logic [31:0] imm,
                      input logic v, input logic [31:0] res);
    exp_t e;
    @(posedge clk); #1;
    rst = r; i_pc = pc; i_read_fetch_data = data; i_rs1_data = a; i_rs2_data = b;
    stim_vld = 1'b1;
    e.name = name; e.instr = r ? 32'd0 : data; e.op = op; e.rd = rd;
    e.imm = imm; e.valid = v; e.rd_data = res; e.addr = pc;
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; i_pc = '0; i_read_fetch_data = '0;
    i_rs1_data = '0; i_rs2_data = '0;
    repeat (2) @(posedge clk);
    //   name          rst pc        data          rs1           rs2           op     rd  imm           v  rd_data
    send("reset",      1, 32'd7,    32'h00500093, 32'd0,        32'd0,        7'h00, 0,  32'h0,        0, 32'h0);
    send("addi",       0, 32'd7,    32'h00500093, 32'd0,        32'd0,        7'h13, 1,  32'd5,        1, 32'd5);
    send("sub_pos",    0, 32'h1234, 32'h40208133, 32'd10,       32'd3,        7'h33, 2,  32'h0,        1, 32'd7);
    send("sub_neg",    0, 32'h1235, 32'h40208133, 32'd3,        32'd10,       7'h33, 2,  32'h0,        1, 32'hFFFFFFF9);
    send("srai",       0, 32'd8,    32'h4040D193, 32'h80000000, 32'd0,        7'h13, 3,  32'h404,      1, 32'hF8000000);
    send("srli",       0, 32'd9,    32'h0040D193, 32'h80000000, 32'd0,        7'h13, 3,  32'h4,        1, 32'h08000000);
    send("lui",        0, 32'd10,   32'h123452B7, 32'd1,        32'd2,        7'h37, 5,  32'h00012345, 1, 32'h0);
    send("sw",         0, 32'd11,   32'h0020A423, 32'd1,        32'd2,        7'h23, 8,  32'd8,        1, 32'h0);
    send("zero_word",  0, 32'd12,   32'h00000000, 32'd1,        32'd2,        7'h00, 0,  32'h0,        0, 32'h0);
    send("sltu_1",     0, 32'd13,   32'h00A0B0B3, 32'd5,        32'd7,        7'h33, 1,  32'h0,        1, 32'd1);
    send("sltu_f7bad", 0, 32'd14,   32'h40A0B0B3, 32'd5,        32'd7,        7'h33, 1,  32'h0,        !STRICT, 32'd1);
    send("beq_m4",     0, 32'd15,   32'hFE000EE3, 32'd0,        32'd0,        7'h63, 29, 32'hFFFFFFFC, 1, 32'h0);
    send("jal",        0, 32'd16,   32'h801000EF, 32'd0,        32'd0,        7'h6F, 1,  32'hFFF00800, 1, 32'h0);
    send("bad_op",     0, 32'd17,   32'h0000007F, 32'd3,        32'd4,        7'h7F, 0,  32'h0,        0, 32'h0);
    send("slt_signed", 0, 32'd18,   32'h0020A0B3, 32'hFFFFFFFF, 32'd1,        7'h33, 1,  32'h0,        1, 32'd1);
    send("sltu_big",   0, 32'd19,   32'h0020B0B3, 32'hFFFFFFFF, 32'd1,        7'h33, 1,  32'h0,        1, 32'd0);
    send("sll_rs2lo",  0, 32'd20,   32'h002090B3, 32'd1,        32'h23,       7'h33, 1,  32'h0,        1, 32'd8);
    send("addi_m1",    0, 32'd21,   32'hFFF08093, 32'd0,        32'd0,        7'h13, 1,  32'hFFFFFFFF, 1, 32'hFFFFFFFF);
    send("addi_nosub", 0, 32'd22,   32'h40008093, 32'd1,        32'd0,        7'h13, 1,  32'h400,      1, 32'h401);
    send("xor",        0, 32'd23,   32'h0020C0B3, 32'hF0F0,     32'hFF00,     7'h33, 1,  32'h0,        1, 32'h0FF0);
    send("or",         0, 32'd24,   32'h0020E0B3, 32'hF0F0,     32'hFF00,     7'h33, 1,  32'h0,        1, 32'hFFF0);
    send("and",        0, 32'd25,   32'h0020F0B3, 32'hF0F0,     32'hFF00,     7'h33, 1,  32'h0,        1, 32'hF000);
    send("srl",        0, 32'd26,   32'h0020D0B3, 32'h80000000, 32'd1,        7'h33, 1,  32'h0,        1, 32'h40000000);
    send("sra",        0, 32'd27,   32'h4020D0B3, 32'h80000000, 32'd1,        7'h33, 1,  32'h0,        1, 32'hC0000000);
    send("add_wrap",   0, 32'd28,   32'h002080B3, 32'hFFFFFFFF, 32'd2,        7'h33, 1,  32'h0,        1, 32'd1);
    send("reset_again",1, 32'hABCD, 32'h002080B3, 32'hFFFFFFFF, 32'd2,        7'h00, 0,  32'h0,        0, 32'h0);
    send("resume",     0, 32'hABCD, 32'h002080B3, 32'hFFFFFFFF, 32'd2,        7'h33, 1,  32'h0,        1, 32'd1);
    @(posedge clk); #1;
    stim_vld = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d entries left expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
